// File: rtl/ysyx_pkg.sv
// Shared definitions for the ysyx store path: store-size encodings, the
// store-buffer entry layout and the lane-mask helper also used by the LSU.
package ysyx_pkg;

    localparam int unsigned YSYX_XLEN  = 32;
    localparam int unsigned YSYX_LANES = YSYX_XLEN / 8;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } store_size_e;

    typedef struct packed {
        logic                   valid;
        logic [YSYX_XLEN-3:0]   wordAddr;
        logic [YSYX_XLEN-1:0]   data;
        logic [YSYX_LANES-1:0]  mask;
    } sb_entry_t;

    // Bit 2 distinguishes signed/unsigned loads only, so it maps to the same mask.
    // Lanes shifted past byte 3 are dropped rather than wrapping.
    function automatic logic [3:0] size_mask(input logic [2:0] funct3, input logic [1:0] off);
        logic [7:0] base;
        case (funct3)
            {1'b0, SZ_B}, {1'b1, SZ_B}: base = 8'h01;
            {1'b0, SZ_H}, {1'b1, SZ_H}: base = 8'h03;
            {1'b0, SZ_W}, {1'b1, SZ_W}: base = 8'h0F;
            default:                    base = 8'h00;
        endcase
        base = base << off;
        return base[3:0];
    endfunction

    function automatic logic [YSYX_XLEN-1:0] lane_expand(input logic [3:0] mask);
        logic [YSYX_XLEN-1:0] bits;
        for (int b = 0; b < 4; b++) begin
            bits[8*b +: 8] = {8{mask[b]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/ysyx_store_buffer_if.sv
// Commit-store, memory-port and load-lookup signals of the store buffer.
interface ysyx_store_buffer_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) ();

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_funct3;
    logic [XLEN-1:0]   in_waddr;
    logic [XLEN-1:0]   in_wdata;

    logic              mem_valid;
    logic              mem_ready;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_wstrb;

    logic [XLEN-1:0]   ld_addr;
    logic [2:0]        ld_funct3;
    logic              ld_hit;
    logic              ld_conflict;
    logic [XLEN-1:0]   ld_data;

    logic [CNT_W-1:0]  count;
    logic              empty;

    modport master (
        output in_valid, in_funct3, in_waddr, in_wdata,
        input  in_ready,
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready,
        output ld_addr, ld_funct3,
        input  ld_hit, ld_conflict, ld_data,
        input  count, empty
    );

    modport slave (
        input  in_valid, in_funct3, in_waddr, in_wdata,
        output in_ready,
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready,
        input  ld_addr, ld_funct3,
        output ld_hit, ld_conflict, ld_data,
        output count, empty
    );

endinterface

// File: rtl/ysyx_sb_fwd.sv
// Combinational load lookup: merges buffered bytes oldest to youngest so the
// youngest matching entry supplies each requested lane.
module ysyx_sb_fwd
    import ysyx_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  sb_entry_t [DEPTH-1:0]  entries_i,
    input  logic [PTR_W-1:0]       head_i,
    input  logic [YSYX_XLEN-1:0]   ld_addr_i,
    input  logic [2:0]             ld_funct3_i,
    output logic                   ld_hit_o,
    output logic                   ld_conflict_o,
    output logic [YSYX_XLEN-1:0]   ld_data_o
);

    logic [3:0]           reqMask;
    logic [3:0]           covered;
    logic [PTR_W-1:0]     idx;
    sb_entry_t            entry;

    always_comb begin
        reqMask   = size_mask(ld_funct3_i, ld_addr_i[1:0]);
        covered   = '0;
        ld_data_o = '0;
        idx       = head_i;
        entry     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx   = head_i + PTR_W'(k);
            entry = entries_i[idx];
            if (entry.valid && entry.wordAddr == ld_addr_i[YSYX_XLEN-1:2]) begin
                for (int b = 0; b < 4; b++) begin
                    if (reqMask[b] && entry.mask[b]) begin
                        covered[b]          = 1'b1;
                        ld_data_o[8*b +: 8] = entry.data[8*b +: 8];
                    end
                end
            end
        end
    end

    // A request with an empty mask (undefined size) is never a hit.
    assign ld_hit_o      = (reqMask != 4'b0) && ((covered & reqMask) == reqMask);
    assign ld_conflict_o = (covered != 4'b0) && !ld_hit_o;

endmodule

// File: rtl/ysyx_store_buffer.sv
// Post-commit store buffer: in-order FIFO of word-aligned byte-lane entries
// drained over a valid/ready memory port, with coalescing and load forwarding.
module ysyx_store_buffer
    import ysyx_pkg::*;
#(
    parameter int unsigned XLEN     = YSYX_XLEN,
    parameter int unsigned DEPTH    = 4,
    parameter bit          COALESCE = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    ysyx_store_buffer_if.slave   sb
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    sb_entry_t [DEPTH-1:0]  entries_q, entries_d;
    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic [1:0]             offset;
    logic [3:0]             pushMask;
    logic [XLEN-1:0]        pushData;
    logic [XLEN-1:0]        pushBits;
    logic [PTR_W-1:0]       youngIdx;
    logic                   full;
    logic                   doPush, doPop, canCoalesce, pushNew;
    sb_entry_t              headEntry;

    assign offset    = sb.in_waddr[1:0];
    assign pushMask  = size_mask(sb.in_funct3, offset);
    assign pushData  = sb.in_wdata << {offset, 3'b000};
    assign pushBits  = lane_expand(pushMask);
    assign youngIdx  = tail_q - PTR_W'(1);
    assign headEntry = entries_q[head_q];

    assign full   = (count_q == CNT_W'(DEPTH));
    assign doPush = sb.in_valid && !full;
    assign doPop  = headEntry.valid && sb.mem_ready;

    // Merging needs two entries so the head, which may be in flight, is never touched.
    assign canCoalesce = COALESCE && (count_q >= CNT_W'(2))
                         && (entries_q[youngIdx].wordAddr == sb.in_waddr[XLEN-1:2]);
    assign pushNew     = doPush && !canCoalesce;

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (doPop) begin
            entries_d[head_q].valid = 1'b0;
            head_d                  = head_q + PTR_W'(1);
        end
        if (doPush) begin
            if (canCoalesce) begin
                entries_d[youngIdx].data = (entries_q[youngIdx].data & ~pushBits)
                                           | (pushData & pushBits);
                entries_d[youngIdx].mask = entries_q[youngIdx].mask | pushMask;
            end else begin
                entries_d[tail_q].valid    = 1'b1;
                entries_d[tail_q].wordAddr = sb.in_waddr[XLEN-1:2];
                entries_d[tail_q].data     = pushData;
                entries_d[tail_q].mask     = pushMask;
                tail_d                     = tail_q + PTR_W'(1);
            end
        end
        case ({pushNew, doPop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            entries_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    assign sb.in_ready  = !full;
    assign sb.mem_valid = headEntry.valid;
    assign sb.mem_addr  = {headEntry.wordAddr, 2'b00};
    assign sb.mem_wdata = headEntry.data;
    assign sb.mem_wstrb = headEntry.mask;
    assign sb.count     = count_q;
    assign sb.empty     = (count_q == '0);

    ysyx_sb_fwd #(
        .DEPTH (DEPTH)
    ) u_fwd (
        .entries_i     (entries_q),
        .head_i        (head_q),
        .ld_addr_i     (sb.ld_addr),
        .ld_funct3_i   (sb.ld_funct3),
        .ld_hit_o      (sb.ld_hit),
        .ld_conflict_o (sb.ld_conflict),
        .ld_data_o     (sb.ld_data)
    );

endmodule

// File: tb/tb_ysyx_store_buffer.sv
// Directed self-checking bench for ysyx_store_buffer (DEPTH=4, COALESCE=1).
module tb_ysyx_store_buffer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    ysyx_store_buffer_if #(.XLEN(32), .DEPTH(4)) sbIf ();

    ysyx_store_buffer #(
        .XLEN     (32),
        .DEPTH    (4),
        .COALESCE (1'b1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .sb    (sbIf)
    );

    // Presents one store for a single clock edge; caller ensures in_ready is high.
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        sbIf.in_valid  = 1'b1;
        sbIf.in_funct3 = f3;
        sbIf.in_waddr  = addr;
        sbIf.in_wdata  = data;
        @(posedge clock);
        #1;
        sbIf.in_valid  = 1'b0;
    endtask

    task automatic setLoad(input logic [2:0] f3, input logic [31:0] addr);
        @(negedge clock);
        sbIf.ld_funct3 = f3;
        sbIf.ld_addr   = addr;
        #1;
    endtask

    task automatic drainAll(input string name);
        int n;
        n = 0;
        sbIf.mem_ready = 1'b1;
        while (sbIf.empty !== 1'b1 && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        sbIf.mem_ready = 1'b0;
        checks++;
        if (sbIf.empty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_drain: empty=%b expected 1 within 20 cycles", name, sbIf.empty);
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        checks++; if (sbIf.mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_valid: got %b expected 0", sbIf.mem_valid); end
        checks++; if (sbIf.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", sbIf.in_ready); end
        checks++; if (sbIf.empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b expected 1", sbIf.empty); end
        checks++; if (sbIf.count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", sbIf.count); end
        checks++; if (sbIf.ld_hit !== 1'b0 || sbIf.ld_conflict !== 1'b0) begin errors++; $display("[TB] FAIL reset_ld: hit=%b conflict=%b expected 0 0", sbIf.ld_hit, sbIf.ld_conflict); end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++; if (sbIf.in_ready !== 1'b1 || sbIf.mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_release: in_ready=%b mem_valid=%b expected 1 0", sbIf.in_ready, sbIf.mem_valid); end
    endtask

    task automatic test_sw_drain();
        sbIf.mem_ready = 1'b1;
        applyStimulus(3'd2, 32'h8000_0004, 32'hDEAD_BEEF);
        checks++; if (sbIf.mem_valid !== 1'b1) begin errors++; $display("[TB] FAIL sw_mem_valid: got %b expected 1", sbIf.mem_valid); end
        checks++; if (sbIf.mem_addr !== 32'h8000_0004) begin errors++; $display("[TB] FAIL sw_mem_addr: got %h expected 80000004", sbIf.mem_addr); end
        checks++; if (sbIf.mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL sw_mem_wdata: got %h expected deadbeef", sbIf.mem_wdata); end
        checks++; if (sbIf.mem_wstrb !== 4'hF) begin errors++; $display("[TB] FAIL sw_mem_wstrb: got %h expected f", sbIf.mem_wstrb); end
        checks++; if (sbIf.count !== 3'd1 || sbIf.empty !== 1'b0) begin errors++; $display("[TB] FAIL sw_count: count=%0d empty=%b expected 1 0", sbIf.count, sbIf.empty); end
        @(posedge clock);
        #1;
        sbIf.mem_ready = 1'b0;
        checks++; if (sbIf.empty !== 1'b1 || sbIf.mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL sw_after_pop: empty=%b mem_valid=%b expected 1 0", sbIf.empty, sbIf.mem_valid); end
    endtask

    task automatic test_sb_hold();
        sbIf.mem_ready = 1'b0;
        applyStimulus(3'd0, 32'h8000_0001, 32'h0000_00AB);
        checks++; if (sbIf.mem_wstrb !== 4'h2) begin errors++; $display("[TB] FAIL sb_wstrb: got %h expected 2", sbIf.mem_wstrb); end
        checks++; if (sbIf.mem_wdata !== 32'h0000_AB00) begin errors++; $display("[TB] FAIL sb_wdata: got %h expected 0000ab00", sbIf.mem_wdata); end
        checks++; if (sbIf.mem_addr !== 32'h8000_0000) begin errors++; $display("[TB] FAIL sb_addr: got %h expected 80000000", sbIf.mem_addr); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            checks++;
            if (sbIf.mem_valid !== 1'b1 || sbIf.mem_addr !== 32'h8000_0000
                || sbIf.mem_wdata !== 32'h0000_AB00 || sbIf.mem_wstrb !== 4'h2) begin
                errors++;
                $display("[TB] FAIL sb_hold_%0d: valid=%b addr=%h wdata=%h wstrb=%h expected 1 80000000 0000ab00 2",
                         i, sbIf.mem_valid, sbIf.mem_addr, sbIf.mem_wdata, sbIf.mem_wstrb);
            end
        end
        sbIf.mem_ready = 1'b1;
        @(posedge clock);
        #1;
        sbIf.mem_ready = 1'b0;
        checks++; if (sbIf.empty !== 1'b1) begin errors++; $display("[TB] FAIL sb_pop: empty=%b expected 1", sbIf.empty); end
    endtask

    task automatic test_full();
        sbIf.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3'd2, 32'h0000_1000 + 32'(4 * i), 32'h0000_00A0 + 32'(i));
        end
        checks++; if (sbIf.count !== 3'd4) begin errors++; $display("[TB] FAIL full_count: got %0d expected 4", sbIf.count); end
        checks++; if (sbIf.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_in_ready: got %b expected 0", sbIf.in_ready); end
        sbIf.in_valid  = 1'b1;
        sbIf.in_funct3 = 3'd2;
        sbIf.in_waddr  = 32'h0000_2000;
        sbIf.in_wdata  = 32'h0000_0055;
        sbIf.mem_ready = 1'b1;
        #1;
        checks++; if (sbIf.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_pop_cycle_in_ready: got %b expected 0", sbIf.in_ready); end
        @(posedge clock);
        #1;
        sbIf.in_valid  = 1'b0;
        sbIf.mem_ready = 1'b0;
        checks++; if (sbIf.in_ready !== 1'b1 || sbIf.count !== 3'd3) begin errors++; $display("[TB] FAIL full_after_pop: in_ready=%b count=%0d expected 1 3", sbIf.in_ready, sbIf.count); end
        sbIf.mem_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (sbIf.mem_addr !== 32'h0000_1000 + 32'(4 * i) || sbIf.mem_wdata !== 32'h0000_00A0 + 32'(i)) begin
                errors++;
                $display("[TB] FAIL full_order_%0d: addr=%h wdata=%h expected %h %h", i, sbIf.mem_addr,
                         sbIf.mem_wdata, 32'h0000_1000 + 32'(4 * i), 32'h0000_00A0 + 32'(i));
            end
            @(posedge clock);
            #1;
        end
        sbIf.mem_ready = 1'b0;
        checks++; if (sbIf.empty !== 1'b1) begin errors++; $display("[TB] FAIL full_drained: empty=%b expected 1", sbIf.empty); end
    endtask

    task automatic test_coalesce();
        sbIf.mem_ready = 1'b0;
        applyStimulus(3'd2, 32'h0000_0100, 32'h1111_1111);
        applyStimulus(3'd2, 32'h0000_0200, 32'h0000_0000);
        applyStimulus(3'd1, 32'h0000_0202, 32'h0000_BEEF);
        checks++; if (sbIf.count !== 3'd2) begin errors++; $display("[TB] FAIL coal_merge_count: got %0d expected 2", sbIf.count); end
        applyStimulus(3'd0, 32'h0000_0103, 32'h0000_00CC);
        checks++; if (sbIf.count !== 3'd3) begin errors++; $display("[TB] FAIL coal_nomerge_count: got %0d expected 3", sbIf.count); end
        checks++; if (sbIf.mem_addr !== 32'h0000_0100 || sbIf.mem_wdata !== 32'h1111_1111) begin errors++; $display("[TB] FAIL coal_head: addr=%h wdata=%h expected 00000100 11111111", sbIf.mem_addr, sbIf.mem_wdata); end
        setLoad(3'd2, 32'h0000_0100);
        checks++; if (sbIf.ld_hit !== 1'b1 || sbIf.ld_data !== 32'hCC11_1111) begin errors++; $display("[TB] FAIL coal_fwd_young: hit=%b data=%h expected 1 cc111111", sbIf.ld_hit, sbIf.ld_data); end
        sbIf.mem_ready = 1'b1;
        @(posedge clock);
        #1;
        sbIf.mem_ready = 1'b0;
        checks++; if (sbIf.mem_addr !== 32'h0000_0200 || sbIf.mem_wstrb !== 4'hF) begin errors++; $display("[TB] FAIL coal_second_strb: addr=%h wstrb=%h expected 00000200 f", sbIf.mem_addr, sbIf.mem_wstrb); end
        checks++; if (sbIf.mem_wdata !== 32'hBEEF_0000) begin errors++; $display("[TB] FAIL coal_second_wdata: got %h expected beef0000", sbIf.mem_wdata); end
        sbIf.mem_ready = 1'b1;
        @(posedge clock);
        #1;
        sbIf.mem_ready = 1'b0;
        checks++; if (sbIf.mem_wstrb !== 4'h8 || sbIf.mem_wdata !== 32'hCC00_0000) begin errors++; $display("[TB] FAIL coal_third: wstrb=%h wdata=%h expected 8 cc000000", sbIf.mem_wstrb, sbIf.mem_wdata); end
        drainAll("coal");
        applyStimulus(3'd2, 32'h0000_0500, 32'h0000_0000);
        applyStimulus(3'd0, 32'h0000_0501, 32'h0000_005A);
        checks++; if (sbIf.count !== 3'd2) begin errors++; $display("[TB] FAIL coal_count1_nomerge: got %0d expected 2", sbIf.count); end
        checks++; if (sbIf.mem_wstrb !== 4'hF || sbIf.mem_wdata !== 32'h0000_0000) begin errors++; $display("[TB] FAIL coal_head_untouched: wstrb=%h wdata=%h expected f 00000000", sbIf.mem_wstrb, sbIf.mem_wdata); end
        drainAll("coal1");
    endtask

    task automatic test_forward();
        sbIf.mem_ready = 1'b0;
        applyStimulus(3'd2, 32'h0000_0300, 32'h4433_2211);
        applyStimulus(3'd0, 32'h0000_0301, 32'h0000_0099);
        setLoad(3'd2, 32'h0000_0300);
        checks++; if (sbIf.ld_hit !== 1'b1 || sbIf.ld_conflict !== 1'b0) begin errors++; $display("[TB] FAIL fwd_lw_flags: hit=%b conflict=%b expected 1 0", sbIf.ld_hit, sbIf.ld_conflict); end
        checks++; if (sbIf.ld_data !== 32'h4433_9911) begin errors++; $display("[TB] FAIL fwd_lw_data: got %h expected 44339911", sbIf.ld_data); end
        setLoad(3'd2, 32'h0000_0400);
        checks++; if (sbIf.ld_hit !== 1'b0 || sbIf.ld_conflict !== 1'b0 || sbIf.ld_data !== 32'h0) begin errors++; $display("[TB] FAIL fwd_miss: hit=%b conflict=%b data=%h expected 0 0 00000000", sbIf.ld_hit, sbIf.ld_conflict, sbIf.ld_data); end
        setLoad(3'd4, 32'h0000_0302);
        checks++; if (sbIf.ld_hit !== 1'b1 || sbIf.ld_data !== 32'h0033_0000) begin errors++; $display("[TB] FAIL fwd_lbu: hit=%b data=%h expected 1 00330000", sbIf.ld_hit, sbIf.ld_data); end
        drainAll("fwd");
        applyStimulus(3'd0, 32'h0000_0305, 32'h0000_0007);
        setLoad(3'd1, 32'h0000_0304);
        checks++; if (sbIf.ld_conflict !== 1'b1 || sbIf.ld_hit !== 1'b0) begin errors++; $display("[TB] FAIL fwd_partial: hit=%b conflict=%b expected 0 1", sbIf.ld_hit, sbIf.ld_conflict); end
        checks++; if (sbIf.ld_data !== 32'h0000_0700) begin errors++; $display("[TB] FAIL fwd_partial_data: got %h expected 00000700", sbIf.ld_data); end
        setLoad(3'd2, 32'h0000_0600);
        sbIf.in_valid  = 1'b1;
        sbIf.in_funct3 = 3'd2;
        sbIf.in_waddr  = 32'h0000_0600;
        sbIf.in_wdata  = 32'h1234_5678;
        #1;
        checks++; if (sbIf.ld_hit !== 1'b0) begin errors++; $display("[TB] FAIL fwd_same_cycle: hit=%b expected 0", sbIf.ld_hit); end
        @(posedge clock);
        #1;
        sbIf.in_valid = 1'b0;
        checks++; if (sbIf.ld_hit !== 1'b1 || sbIf.ld_data !== 32'h1234_5678) begin errors++; $display("[TB] FAIL fwd_next_cycle: hit=%b data=%h expected 1 12345678", sbIf.ld_hit, sbIf.ld_data); end
        drainAll("fwd2");
    endtask

    task automatic test_reset_mid();
        sbIf.mem_ready = 1'b0;
        applyStimulus(3'd2, 32'h0000_0700, 32'h0000_0001);
        applyStimulus(3'd2, 32'h0000_0704, 32'h0000_0002);
        applyStimulus(3'd2, 32'h0000_0708, 32'h0000_0003);
        checks++; if (sbIf.mem_valid !== 1'b1 || sbIf.count !== 3'd3) begin errors++; $display("[TB] FAIL rst_mid_pre: mem_valid=%b count=%0d expected 1 3", sbIf.mem_valid, sbIf.count); end
        #2 reset = 1'b0;
        #1;
        checks++; if (sbIf.mem_valid !== 1'b0 || sbIf.count !== 3'd0) begin errors++; $display("[TB] FAIL rst_mid_async: mem_valid=%b count=%0d expected 0 0", sbIf.mem_valid, sbIf.count); end
        checks++; if (sbIf.empty !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_empty: got %b expected 1", sbIf.empty); end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++; if (sbIf.in_ready !== 1'b1 || sbIf.mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_release: in_ready=%b mem_valid=%b expected 1 0", sbIf.in_ready, sbIf.mem_valid); end
        setLoad(3'd2, 32'h0000_0700);
        checks++; if (sbIf.ld_hit !== 1'b0 || sbIf.ld_conflict !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_fwd: hit=%b conflict=%b expected 0 0", sbIf.ld_hit, sbIf.ld_conflict); end
    endtask

    initial begin
        sbIf.in_valid  = 1'b0;
        sbIf.in_funct3 = 3'd0;
        sbIf.in_waddr  = 32'h0;
        sbIf.in_wdata  = 32'h0;
        sbIf.mem_ready = 1'b0;
        sbIf.ld_addr   = 32'h0;
        sbIf.ld_funct3 = 3'd2;
        test_reset();
        test_sw_drain();
        test_sb_hold();
        test_full();
        test_coalesce();
        test_forward();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
